// File: rtl/vme_mem_pkg.sv
// Shared types for the VME memory-strobe initiator.
//   state_t : initiator FSM states
//   cmd_t   : latched command {we, addr, wdata}
//   rsp_t   : response payload {rdata, err}
//   CNT_W   : timeout counter width, covers TIMEOUT up to 255
package vme_mem_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = $clog2(256);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_t;

endpackage

// File: rtl/vme_mem_initiator_if.sv
// Command, response and VME memory-strobe signals of the initiator.
//   master : initiator side (drives cmd_ready, rsp_*, VME strobes/addr/data, busy)
//   slave  : controller + responder side
interface vme_mem_initiator_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] VMEAddr;
  logic [DATA_WIDTH-1:0] VMEWrData;
  logic                  VMERdMem;
  logic                  VMEWrMem;
  logic [DATA_WIDTH-1:0] VMERdData;
  logic                  VMERdDone;
  logic                  VMEWrDone;
  logic                  busy;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    input  VMERdData, VMERdDone, VMEWrDone,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output VMEAddr, VMEWrData, VMERdMem, VMEWrMem, busy
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    output VMERdData, VMERdDone, VMEWrDone,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  VMEAddr, VMEWrData, VMERdMem, VMEWrMem, busy
  );

endinterface

// File: rtl/vme_mem_timeout_cnt.sv
// Done-wait timeout counter: load with TIMEOUT, decrement while waiting.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : reload with TIMEOUT
//   dec        : count down one step
//   expired_c  : the current decrement reaches zero (counter at 1)
module vme_mem_timeout_cnt
  import vme_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic expired_c
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CNT_W'(TIMEOUT);
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expired_c = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/vme_mem_initiator.sv
// VME memory-strobe initiator: one single-beat access per accepted command,
// waits for the matching Done and returns {rdata, err}.
// Optional macro VME_MEM_INITIATOR_TIMEOUT_EN enables the Done timeout and
// rsp_err; without it WAIT holds until the matching Done and rsp_err stays 0.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : command stream, response stream, VME strobes/acks, busy
module vme_mem_initiator
  import vme_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  vme_mem_initiator_if.master bus
);

  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("vme_mem_initiator: TIMEOUT must be within 1..255");
  end

  state_t state_q, state_d;
  cmd_t   cmd_q, cmd_d;
  rsp_t   rsp_q, rsp_d;
  logic   rsp_valid_q, rsp_valid_d;
  logic   rd_mem_q, rd_mem_d;
  logic   wr_mem_q, wr_mem_d;
  logic   busy_q, busy_d;
  logic   done_c;
  logic   timeout_c;

`ifdef VME_MEM_INITIATOR_TIMEOUT_EN
  logic cnt_load_c;
  logic cnt_dec_c;
  logic expired_c;

  vme_mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cnt_load_c),
    .dec       (cnt_dec_c),
    .expired_c (expired_c)
  );

  assign timeout_c = expired_c;
`else
  assign timeout_c = 1'b0;
`endif

  // Only the ack matching the current direction counts.
  assign done_c = cmd_q.we ? bus.VMEWrDone : bus.VMERdDone;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    rd_mem_d    = 1'b0;
    wr_mem_d    = 1'b0;
`ifdef VME_MEM_INITIATOR_TIMEOUT_EN
    cnt_load_c  = 1'b0;
    cnt_dec_c   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          cmd_d.we   = bus.cmd_we;
          cmd_d.addr = ADDR_W'(bus.cmd_addr);
          // Reads leave the bus write data untouched.
          if (bus.cmd_we) cmd_d.wdata = DATA_W'(bus.cmd_wdata);
          rd_mem_d = !bus.cmd_we;
          wr_mem_d = bus.cmd_we;
          state_d  = STROBE;
        end
      end
      STROBE: begin
`ifdef VME_MEM_INITIATOR_TIMEOUT_EN
        cnt_load_c = 1'b1;
`endif
        // A zero-latency responder acks in the strobe cycle itself.
        if (done_c) begin
          rsp_d.rdata = cmd_q.we ? '0 : DATA_W'(bus.VMERdData);
          rsp_d.err   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (done_c) begin
          rsp_d.rdata = cmd_q.we ? '0 : DATA_W'(bus.VMERdData);
          rsp_d.err   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (timeout_c) begin
          rsp_d.rdata = '0;
          rsp_d.err   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
`ifdef VME_MEM_INITIATOR_TIMEOUT_EN
        else begin
          cnt_dec_c = 1'b1;
        end
`endif
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      rd_mem_q    <= 1'b0;
      wr_mem_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      rd_mem_q    <= rd_mem_d;
      wr_mem_q    <= wr_mem_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = DATA_WIDTH'(rsp_q.rdata);
  assign bus.rsp_err   = rsp_q.err;
  assign bus.VMEAddr   = ADDR_WIDTH'(cmd_q.addr);
  assign bus.VMEWrData = DATA_WIDTH'(cmd_q.wdata);
  assign bus.VMERdMem  = rd_mem_q;
  assign bus.VMEWrMem  = wr_mem_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/vme_mem_initiator.md
Name: vme_mem_initiator

Overview:
Initiator end of the single-beat VME memory-strobe interface (VMERdMem/VMEWrMem strobes, VMERdDone/VMEWrDone acks) used by the team's register-bank responders. It converts a valid/ready command stream into one bus access at a time, waits for the matching Done, and returns a response with read data and an error flag. It sits between a local controller or CPU-side bridge and one generated register bank.

Parameters:
ADDR_WIDTH, 8, width of VMEAddr and cmd_addr.
DATA_WIDTH, 32, width of read and write data.
TIMEOUT, 15, cycles to wait for Done before flagging an error; legal range 1..255.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
cmd_we  in  1  1 = write, 0 = read.
cmd_addr  in  ADDR_WIDTH  target address.
cmd_wdata  in  DATA_WIDTH  write data.
rsp_valid  out  1  response present.
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
rsp_err  out  1  timeout occurred.
VMEAddr  out  ADDR_WIDTH  bus address.
VMEWrData  out  DATA_WIDTH  bus write data.
VMERdMem  out  1  read strobe, one-cycle pulse.
VMEWrMem  out  1  write strobe, one-cycle pulse.
VMERdData  in  DATA_WIDTH  responder read data, valid while VMERdDone = 1.
VMERdDone  in  1  read acknowledge pulse.
VMEWrDone  in  1  write acknowledge pulse.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: rst_n, synchronous, active-low.
- Values while in reset: state IDLE; all outputs 0 except cmd_ready = 1 on the first cycle after release.
- All outputs are registered except cmd_ready, which equals (state == IDLE).
- States: IDLE, STROBE, WAIT, RESP.
- IDLE:
  - On accept at cycle T, latch we, addr and wdata into VMEAddr/VMEWrData. For reads, VMEWrData keeps its previous value.
  - Go to STROBE.
- STROBE (cycle T+1):
  - Assert VMERdMem (read) or VMEWrMem (write) for exactly this one cycle.
  - Load timeout counter with TIMEOUT.
  - Go to WAIT.
  - A matching Done already sampled in this cycle is honoured: go directly to RESP.
- WAIT:
  - Each cycle, sample only the matching Done: VMERdDone for reads, VMEWrDone for writes. The non-matching Done is ignored.
  - On a matching Done at cycle D:
    - Capture rsp_rdata = VMERdData for reads, 0 for writes.
    - Set rsp_err = 0 and rsp_valid = 1 at D+1.
    - Go to RESP.
  - Otherwise decrement the counter. On reaching 0: rsp_rdata = 0, rsp_err = 1, rsp_valid = 1, go to RESP.
- RESP:
  - Hold rsp_* stable until rsp_ready.
  - On handshake: rsp_valid = 0, go to IDLE. The next command is accepted no earlier than the following cycle.
- VMEAddr and VMEWrData stay stable from STROBE until the next accept.
- Done pulses in IDLE, RESP or STROBE-less cycles (stray or late after timeout) are ignored and never generate a response.
- Minimum round trip with a zero-latency responder (Done in the strobe cycle): accept T, strobe T+1, rsp_valid T+2.
- Reset mid-transaction: abort immediately, drop strobe and response, return to IDLE. No response is ever issued for the aborted command.

Optional Feature:
- Macro: VME_MEM_INITIATOR_TIMEOUT_EN.
- Defined: timeout counter and rsp_err behaviour as above.
- Undefined:
  - No counter is instantiated.
  - WAIT holds until a matching Done arrives.
  - rsp_err is tied to 0.
  - The TIMEOUT parameter is unused.

Decomposition:
- Shared package vme_mem_pkg holds:
  - the state enum (IDLE, STROBE, WAIT, RESP);
  - a command struct {we, addr, wdata};
  - a response struct {rdata, err};
  - a localparam for the counter width, $clog2(256).
- One sub-module, vme_mem_timeout_cnt: load/decrement/expired, instantiated only under the macro.

Test Plan:
1. Write, responder acks 2 cycles after the strobe:
   - Stimulus: cmd_we = 1, addr 0x04, wdata 0x0000BEEF.
   - Required: VMEWrMem pulses exactly once, VMEAddr = 0x04, VMEWrData = 0x0000BEEF.
   - Required: rsp_valid with rsp_err = 0 and rdata = 0 one cycle after VMEWrDone.
2. Read with zero-latency Done:
   - Stimulus: Done in the strobe cycle, VMERdData = 0x0000CAFE.
   - Required: rsp_valid at T+2, rsp_rdata = 0x0000CAFE.
3. Backpressure:
   - Stimulus: rsp_ready held low 5 cycles; cmd_valid held high with a second command.
   - Required: rsp fields stable; cmd_ready = 0; second strobe appears only after the response handshake.
4. Timeout (macro defined, TIMEOUT = 4):
   - Stimulus: read with no Done.
   - Required: rsp_err = 1 and rdata = 0 after 4 wait cycles.
   - Stimulus: late VMERdDone 2 cycles later.
   - Required: no second response.
5. Wrong-direction and stray acks:
   - Stimulus: VMEWrDone during a read.
   - Required: ignored; the read completes only on VMERdDone.
   - Stimulus: VMERdDone in IDLE.
   - Required: no rsp_valid.
6. Reset mid-WAIT:
   - Stimulus: assert rst_n low for 1 cycle.
   - Required: busy = 0, cmd_ready = 1 after release; subsequent Done ignored; a fresh write completes normally.
